// File: rtl/dvbc_derandomizer.sv
// dvbc_derandomizer: DVB-C energy-dispersal removal (PRBS 1+x^14+x^15) on a sync-aligned TS byte stream
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_data/in_valid/in_sop       RS-decoded byte stream, in_sop marks packet sync byte
//   in_ready                      upstream handshake, free when output register is empty or draining
//   out_data/out_valid/out_sop    derandomized bytes, syncs restored to 0x47
//   out_ready                     downstream handshake
//   locked                        group sync (0xB8) acquired
//   sync_err                      one-cycle pulse per bad sync byte while locked
module dvbc_derandomizer #(
    parameter int PKT_LEN   = 188,
    parameter int GROUP_LEN = 8,
    parameter int LOSS_CNT  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_sop,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_sop,
    input  logic       out_ready,
    output logic       locked,
    output logic       sync_err
);
    localparam int BW = $clog2(PKT_LEN);
    localparam int PW = $clog2(GROUP_LEN + 1);
    localparam int CW = $clog2(LOSS_CNT + 1);
    // bit k of the vector is register stage r_k; init r1..r15 = 100101010000000
    localparam logic [15:1] PRBS_INIT = 15'b000000010101001;
    localparam logic [7:0] SYNC = 8'h47;
    localparam logic [7:0] SYNC_INV = 8'hB8;
    typedef enum logic {HUNT, LOCKED} state_t;
    state_t state;
    logic [BW-1:0] byte_cnt;
    logic [PW-1:0] pkt_idx;
    logic [CW-1:0] bad_cnt;
    logic [15:1] prbs, prbs_adv;
    logic [7:0] prbs_byte;
    logic xfer, sync_pos, first_pkt, last_byte, last_pkt, good_sync, bad_sync, lose;
    assign in_ready = out_ready || !out_valid;
    assign xfer = in_valid && in_ready;
    assign sync_pos = byte_cnt == '0;
    assign first_pkt = pkt_idx == '0;
    assign last_byte = byte_cnt == BW'(PKT_LEN - 1);
    assign last_pkt = pkt_idx == PW'(GROUP_LEN - 1);
    assign good_sync = in_sop && in_data == (first_pkt ? SYNC_INV : SYNC);
    // a sync flag away from the sync position is also a sync fault
    assign bad_sync = sync_pos ? !good_sync : in_sop;
    assign lose = bad_sync && bad_cnt == CW'(LOSS_CNT - 1);
    // eight LFSR steps unrolled; the first generated bit is the byte MSB
    always_comb begin
        prbs_adv = prbs;
        prbs_byte = '0;
        for (int i = 7; i >= 0; i--) begin
            prbs_byte[i] = prbs_adv[14] ^ prbs_adv[15];
            prbs_adv = {prbs_adv[14:1], prbs_byte[i]};
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
            locked <= 1'b0;
            sync_err <= 1'b0;
            out_data <= '0;
            out_valid <= 1'b0;
            out_sop <= 1'b0;
            byte_cnt <= '0;
            pkt_idx <= '0;
            bad_cnt <= '0;
            prbs <= PRBS_INIT;
        end else begin
            sync_err <= 1'b0;
            if (out_ready) out_valid <= 1'b0;
            if (xfer) begin
                if (state == HUNT) begin
                    if (in_sop && in_data == SYNC_INV) begin
                        state <= LOCKED;
                        locked <= 1'b1;
                        byte_cnt <= BW'(1);
                        pkt_idx <= '0;
                        bad_cnt <= '0;
                        prbs <= PRBS_INIT;
                        out_valid <= 1'b1;
                        out_data <= SYNC;
                        out_sop <= 1'b1;
                    end
                end else begin
                    byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
                    if (last_byte) pkt_idx <= last_pkt ? '0 : pkt_idx + 1'b1;
                    // the group-opening sync restarts the sequence, later syncs only consume it
                    prbs <= (sync_pos && first_pkt) ? PRBS_INIT : prbs_adv;
                    out_data <= sync_pos ? SYNC : in_data ^ prbs_byte;
                    out_sop <= sync_pos;
                    sync_err <= bad_sync;
                    if (sync_pos && good_sync) bad_cnt <= '0;
                    else if (bad_sync) bad_cnt <= bad_cnt + 1'b1;
                    if (lose) begin
                        state <= HUNT;
                        locked <= 1'b0;
                        byte_cnt <= '0;
                        pkt_idx <= '0;
                        bad_cnt <= '0;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_dvbc_derandomizer.sv
// tb_dvbc_derandomizer: directed-vector and model-based checks for dvbc_derandomizer
module tb_dvbc_derandomizer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] in_data = '0;
    logic in_valid = 1'b0;
    logic in_sop = 1'b0;
    logic out_ready = 1'b1;
    logic in_ready, out_valid, out_sop, locked, sync_err;
    logic [7:0] out_data;

    dvbc_derandomizer dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_ready(out_ready),
        .locked(locked), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic sop;
        logic [7:0] ed;
        logic es;
    } vec_t;

    int total = 0, passed = 0, serr = 0, vcnt = 0, stab_err = 0;
    bit stall_en = 0, gap_en = 0;
    bit x [0:12038];
    logic [8:0] got_q[$], exp_q[$];
    logic [7:0] sent [0:187];
    logic stall_prev = 1'b0;
    logic [8:0] hold = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // PRBS byte j of a group, taken from the bit recurrence s[n] = s[n-14] ^ s[n-15]
    function automatic logic [7:0] pb(input int j);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[7-k] = x[15 + 8*j + k];
        return r;
    endfunction

    function automatic logic [7:0] orig(input int q, input int b);
        return 8'(q*16 + b);
    endfunction

    always @(negedge clk) begin
        if (stall_prev && (!out_valid || {out_sop, out_data} !== hold)) stab_err++;
        stall_prev = out_valid && !out_ready && rst_n;
        hold = {out_sop, out_data};
        if (out_valid && out_ready) got_q.push_back({out_sop, out_data});
        if (sync_err) serr++;
        if (out_valid) vcnt++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic send(input logic [7:0] d, input logic s);
        int n = 0;
        logic acc;
        if (gap_en) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data = d;
        in_sop = s;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 1000) begin
                total++;
                $display("FAIL accept timeout: in_ready low for %0d cycles, required high", n);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_pkt(input int q, input int g, input logic [7:0] sb, input bit expect_out);
        send(sb, 1'b1);
        if (expect_out) exp_q.push_back({1'b1, 8'h47});
        for (int b = 1; b < 188; b++) begin
            send(orig(q, b) ^ pb(g*188 + b - 1), 1'b0);
            if (expect_out) exp_q.push_back({1'b0, orig(q, b)});
        end
    endtask

    task automatic drain();
        stall_en = 0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic compare(input string name);
        int errs = 0;
        int n = got_q.size() < exp_q.size() ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (got_q[i] !== exp_q[i]) begin
                if (errs == 0) $display("%s first diff at byte %0d: got %h expected %h", name, i, got_q[i], exp_q[i]);
                errs++;
            end
        check({name, " length"}, got_q.size(), exp_q.size());
        check({name, " bytes"}, errs, 0);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        vec_t tv [5];
        tv[0] = '{8'hB8, 1'b1, 8'h47, 1'b1};
        tv[1] = '{8'h00, 1'b0, 8'h03, 1'b0};
        tv[2] = '{8'h00, 1'b0, 8'hF6, 1'b0};
        tv[3] = '{8'hFF, 1'b0, 8'hF7, 1'b0};
        tv[4] = '{8'h34, 1'b0, 8'h00, 1'b0};
        for (int i = 0; i < 15; i++) x[i] = 0;
        x[7] = 1; x[9] = 1; x[11] = 1; x[14] = 1;
        for (int n = 15; n <= 12038; n++) x[n] = x[n-14] ^ x[n-15];

        repeat (2) @(negedge clk);
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 0);
        check("reset out_sop", out_sop, 0);
        check("reset locked", locked, 0);
        check("reset sync_err", sync_err, 0);
        check("reset in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            send(tv[i].d, tv[i].sop);
            sent[i] = tv[i].d;
            check($sformatf("vector %0d", i), {out_valid, out_sop, out_data}, {1'b1, tv[i].es, tv[i].ed});
            if (i == 0) begin
                check("locked after B8", locked, 1);
                check("no sync_err on lock", sync_err, 0);
            end
        end
        for (int b = 5; b < 90; b++) begin
            send(8'h00, 1'b0);
            sent[b] = 8'h00;
        end
        exp_q.push_back({1'b1, 8'h47});
        for (int b = 1; b < 89; b++) exp_q.push_back({1'b0, sent[b] ^ pb(b - 1)});
        compare("pre reset");
        check("valid before reset", out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        check("reset mid-packet out_valid", out_valid, 0);
        check("reset mid-packet locked", locked, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        got_q.delete();

        serr = 0;
        for (int q = 0; q < 16; q++) send_pkt(q, q % 8, (q % 8 == 0) ? 8'hB8 : 8'h47, 1);
        drain();
        compare("roundtrip");
        check("roundtrip sync_err", serr, 0);
        check("roundtrip locked", locked, 1);

        serr = 0;
        stab_err = 0;
        stall_en = 1;
        gap_en = 1;
        for (int q = 0; q < 16; q++) send_pkt(q, q % 8, (q % 8 == 0) ? 8'hB8 : 8'h47, 1);
        gap_en = 0;
        drain();
        compare("stalled");
        check("stalled hold stable", stab_err, 0);
        check("stalled sync_err", serr, 0);

        serr = 0;
        for (int g = 0; g < 8; g++) send_pkt(100 + g, g, (g == 0) ? 8'hB8 : (g == 3) ? 8'h46 : 8'h47, 1);
        drain();
        compare("one bad sync");
        check("one bad sync pulses", serr, 1);
        check("one bad sync locked", locked, 1);

        serr = 0;
        for (int g = 0; g < 3; g++) send_pkt(200 + g, g, (g == 0) ? 8'hB8 : 8'h46, 1);
        check("locked after two bad", locked, 1);
        send(8'h46, 1'b1);
        check("locked at third bad", locked, 0);
        check("third bad dropped", out_valid, 0);
        vcnt = 0;
        for (int b = 1; b < 188; b++) send(orig(203, b) ^ pb(3*188 + b - 1), 1'b0);
        for (int g = 4; g < 8; g++) send_pkt(200 + g, g, 8'h47, 0);
        drain();
        compare("loss");
        check("loss sync_err pulses", serr, 3);
        check("hunt out_valid count", vcnt, 0);
        check("hunt locked", locked, 0);

        send(8'hB8, 1'b1);
        check("relock locked", locked, 1);
        check("relock sync out", {out_valid, out_sop, out_data}, {1'b1, 1'b1, 8'h47});
        exp_q.push_back({1'b1, 8'h47});
        send(8'h55, 1'b0);
        check("relock first data", out_data, 8'h56);
        exp_q.push_back({1'b0, 8'h56});
        for (int b = 2; b < 188; b++) begin
            send(orig(300, b) ^ pb(b - 1), 1'b0);
            exp_q.push_back({1'b0, orig(300, b)});
        end
        drain();
        compare("relock");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/dvbc_derandomizer.md
Name: dvbc_derandomizer

Overview:
Receive-side inverse of the DVB-C energy-dispersal randomizer (EN 300 429 / ETS 300 421 PRBS 1+x^14+x^15). It accepts a sync-aligned MPEG-TS byte stream after RS decoding and synchronises to the inverted sync byte 0xB8 that opens each 8-packet group. It then removes the PRBS from every non-sync byte and restores 0xB8 to 0x47. It sits between the RS decoder and the TS output interface.

Parameters:
PKT_LEN, 188, bytes per TS packet including the sync byte
GROUP_LEN, 8, packets per PRBS period (the inverted sync repeats every GROUP_LEN packets)
LOSS_CNT, 3, consecutive bad sync bytes in LOCKED that force a return to HUNT

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
in_data  in  8  input byte, MSB is first bit on air
in_valid  in  1  in_data valid
in_sop  in  1  marks the sync byte position of a packet, qualified by in_valid
in_ready  out  1  input accepted when in_valid && in_ready
out_data  out  8  derandomized byte
out_valid  out  1  out_data valid
out_sop  out  1  out_data is a sync byte (always 0x47 when asserted)
out_ready  in  1  downstream accepts when out_valid && out_ready
locked  out  1  group synchronisation acquired
sync_err  out  1  one-cycle pulse per bad sync byte detected while LOCKED

Behaviour:
- Reset values: out_data=0, out_valid=0, out_sop=0, locked=0, sync_err=0, state=HUNT, PRBS=init, byte_cnt=0, pkt_idx=0, bad_cnt=0.
- in_ready = out_ready || !out_valid, a one-deep registered output stage. A transfer occurs only on in_valid && in_ready. All state advances only on a transfer.
- Latency: 1 cycle, input transfer to out_valid. A stalled output holds out_data and out_sop stable.
- PRBS: 15-bit register r[1..15], init 100101010000000 (r1..r15). Per bit: fb = r14 ^ r15; shift r1<=fb; the output bit is fb. A byte takes 8 consecutive bits, the first bit being the MSB. The next state for the whole byte is computed in one cycle.
- Byte position: byte_cnt counts 0..PKT_LEN-1 per transfer. pkt_idx counts 0..GROUP_LEN-1 and increments when byte_cnt wraps.
- HUNT: outputs are dropped (out_valid stays 0) while in_ready still accepts. A transfer with in_sop=1 and in_data=0xB8 moves to LOCKED with locked=1, byte_cnt=1, pkt_idx=0 and the PRBS loaded with init (no advance on this byte). This byte is emitted as 0x47 with out_sop=1.
- LOCKED, sync position (byte_cnt==0):
  - Expected sync is 0xB8 if pkt_idx==0, otherwise 0x47. The byte is good if in_sop=1 and in_data equals the expected value.
  - pkt_idx==0: the PRBS reloads init.
  - pkt_idx!=0: the PRBS advances 8 bits, but the sync byte is not XORed.
  - Output is always 0x47 with out_sop=1.
  - A good byte clears bad_cnt.
  - A bad byte pulses sync_err and increments bad_cnt. When bad_cnt reaches LOSS_CNT the block goes to HUNT, drops locked, and discards this byte.
- LOCKED, in_sop=1 at byte_cnt!=0: counts as a bad sync (sync_err, bad_cnt++). The byte is XORed as data and the counters are not realigned.
- LOCKED, data byte: out_data = in_data ^ prbs_byte, then the PRBS advances 8 bits, out_sop=0.
- sync_err is registered and high for exactly one clk per offending transfer.
- Asynchronous reset mid-packet returns all state to the reset values immediately. Output restarts only after the next 0xB8 sync in HUNT.

Test Plan:
- Reset, then 0xB8 with in_sop followed by 187 bytes of 0x00 -> out sync 0x47 with out_sop=1; first data bytes 0x03, 0xF6; locked=1 one cycle after the 0xB8 transfer.
- Round trip: 16 packets of incrementing payload randomized by a reference model (or the existing randomizer) -> output equals the original packets; syncs all 0x47; sync_err never pulses.
- Random out_ready stalls (50%) with random in_valid gaps -> output byte sequence identical to the unstalled run; no byte lost or duplicated; out_data stable while stalled.
- In LOCKED, corrupt the sync of packet 3 to 0x46 -> one sync_err pulse; locked stays 1. Corrupt 3 consecutive sync positions -> locked falls at the third; outputs stop until the next 0xB8.
- HUNT with 0x47-synced packets only -> out_valid never asserts and locked=0. A 0xB8 then arrives -> lock on that packet and first data byte XOR 0x03.
- Assert rst_n low mid-packet (byte 90) -> out_valid=0 and locked=0 immediately. A new 0xB8 group after release is descrambled from PRBS init.
